// File: rtl/vend_pkg.sv
// Shared coin/state encodings for the vending sequencer.
// Coin values are expressed in Rs5 credit units.
package vend_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    C5   = 2'b01,
    C10  = 2'b10,
    BAD  = 2'b11
  } coin_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    VEND   = 2'b01,
    PAYOUT = 2'b10
  } vend_state_t;

  localparam int COIN_VAL_C5  = 1;
  localparam int COIN_VAL_C10 = 2;

endpackage

// File: rtl/vend_change_payout.sv
// Change payout loop: offers Rs10 coins while >=2 units remain, then Rs5; one coin per ack.
// Offer registered the cycle after load; change/change_valid held until change_ack.
module vend_change_payout
  import vend_pkg::*;
#(
  parameter int CRED_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [CRED_W-1:0] load_cred,
  output logic              change_valid,
  output logic [1:0]        change,
  input  logic              change_ack,
  output logic [CRED_W-1:0] paid,
  output logic              done
);

  logic [CRED_W-1:0] rem;
  logic [CRED_W-1:0] nxt_rem;
  logic              took;

  function automatic coin_t pick(input logic [CRED_W-1:0] amt);
    return (amt >= CRED_W'(COIN_VAL_C10)) ? C10 : C5;
  endfunction

  assign took    = change_valid && change_ack;
  assign paid    = !took ? '0 :
                   (change == C10) ? CRED_W'(COIN_VAL_C10) : CRED_W'(COIN_VAL_C5);
  assign nxt_rem = rem - paid;
  // done flags the final ack so the owner can leave PAYOUT on the same edge
  assign done    = took && (nxt_rem == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem          <= '0;
      change_valid <= 1'b0;
      change       <= NONE;
    end else if (load) begin
      rem          <= load_cred;
      change_valid <= (load_cred != '0);
      change       <= (load_cred == '0) ? NONE : pick(load_cred);
    end else if (took) begin
      rem <= nxt_rem;
      if (nxt_rem == '0) begin
        change_valid <= 1'b0;
        change       <= NONE;
      end else begin
        change <= pick(nxt_rem);
      end
    end
  end

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: coin credit, slot price/stock arbitration, motor then change handshakes.
// motor_req one cycle after accepted selection; optional refund input under COIN_RETURN_EN.
module vend_controller
  import vend_pkg::*;
#(
  parameter int NUM_PROD = 4,
  parameter int CRED_W   = 5,
  parameter int STOCK_W  = 4,
  parameter int MAX_CRED = 10,
  localparam int IDX_W   = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          coin,
  output logic                coin_reject,
  input  logic                sel_valid,
  input  logic [IDX_W-1:0]    sel_idx,
  output logic                sel_ready,
  output logic                sel_deny,
`ifdef COIN_RETURN_EN
  input  logic                cancel,
`endif
  output logic                motor_req,
  output logic [IDX_W-1:0]    motor_idx,
  input  logic                motor_ack,
  output logic                change_valid,
  output logic [1:0]          change,
  input  logic                change_ack,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [CRED_W-1:0]   cfg_price,
  input  logic [STOCK_W-1:0]  cfg_stock,
  output logic [CRED_W-1:0]   credit,
  output logic [NUM_PROD-1:0] sold_out,
  output logic                busy
);

  vend_state_t        state;
  logic [CRED_W-1:0]  price [NUM_PROD];
  logic [STOCK_W-1:0] stock [NUM_PROD];

  logic               cancel_req;
  logic               in_idle;
  logic [CRED_W-1:0]  sel_price;
  logic [STOCK_W-1:0] sel_stock;
  logic               cfg_hit;
  logic               sel_ok;
  logic               sel_bad;
  logic               refund_go;
  logic [CRED_W:0]    coin_add;
  logic [CRED_W:0]    coin_sum;
  logic               coin_ok;
  logic               coin_bad;
  logic               pay_load;
  logic [CRED_W-1:0]  paid;
  logic               pay_done;

`ifdef COIN_RETURN_EN
  assign cancel_req = cancel;
`else
  assign cancel_req = 1'b0;
`endif

  assign in_idle   = (state == IDLE);
  assign sel_ready = in_idle;
  assign busy      = !in_idle;

  assign sel_price = price[sel_idx];
  assign sel_stock = stock[sel_idx];
  // a same-cycle config write to the selected slot takes precedence over the sale
  assign cfg_hit   = cfg_we && (cfg_idx == sel_idx);
  assign sel_ok    = in_idle && sel_valid && (sel_price != '0) && (sel_stock != '0) &&
                     (credit >= sel_price) && !cfg_hit;
  assign sel_bad   = in_idle && sel_valid && !sel_ok;
  assign refund_go = in_idle && cancel_req && !sel_ok && (credit != '0);

  always_comb begin
    coin_add = '0;
    case (coin)
      C5:      coin_add = (CRED_W+1)'(COIN_VAL_C5);
      C10:     coin_add = (CRED_W+1)'(COIN_VAL_C10);
      default: coin_add = '0;
    endcase
  end

  assign coin_sum = {1'b0, credit} + coin_add;
  assign coin_ok  = in_idle && ((coin == C5) || (coin == C10)) &&
                    (coin_sum <= (CRED_W+1)'(MAX_CRED)) && !sel_ok && !refund_go;
  assign coin_bad = (coin != NONE) && !coin_ok;

  assign pay_load = refund_go || ((state == VEND) && motor_ack && (credit != '0));

  always_comb begin
    sold_out = '0;
    for (int i = 0; i < NUM_PROD; i++) sold_out[i] = (stock[i] == '0);
  end

  vend_change_payout #(.CRED_W(CRED_W)) u_payout (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (pay_load),
    .load_cred    (credit),
    .change_valid (change_valid),
    .change       (change),
    .change_ack   (change_ack),
    .paid         (paid),
    .done         (pay_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      credit      <= '0;
      coin_reject <= 1'b0;
      sel_deny    <= 1'b0;
      motor_req   <= 1'b0;
      motor_idx   <= '0;
      for (int i = 0; i < NUM_PROD; i++) begin
        price[i] <= '0;
        stock[i] <= '0;
      end
    end else begin
      coin_reject <= coin_bad;
      sel_deny    <= sel_bad;
      case (state)
        IDLE: begin
          if (cfg_we) begin
            price[cfg_idx] <= cfg_price;
            stock[cfg_idx] <= cfg_stock;
          end
          if (sel_ok) begin
            credit         <= credit - sel_price;
            stock[sel_idx] <= sel_stock - STOCK_W'(1);
            motor_req      <= 1'b1;
            motor_idx      <= sel_idx;
            state          <= VEND;
          end else if (refund_go) begin
            state <= PAYOUT;
          end else if (coin_ok) begin
            credit <= coin_sum[CRED_W-1:0];
          end
        end
        VEND: begin
          if (motor_ack) begin
            motor_req <= 1'b0;
            state     <= (credit != '0) ? PAYOUT : IDLE;
          end
        end
        PAYOUT: begin
          credit <= credit - paid;
          if (pay_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller with hand-computed expectations.
module tb_vend_controller;
  import vend_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] coin;
  logic       coin_reject;
  logic       sel_valid;
  logic [1:0] sel_idx;
  logic       sel_ready;
  logic       sel_deny;
  logic       cancel;
  logic       motor_req;
  logic [1:0] motor_idx;
  logic       motor_ack;
  logic       change_valid;
  logic [1:0] change;
  logic       change_ack;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [4:0] cfg_price;
  logic [3:0] cfg_stock;
  logic [4:0] credit;
  logic [3:0] sold_out;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  vend_controller dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .coin         (coin),
    .coin_reject  (coin_reject),
    .sel_valid    (sel_valid),
    .sel_idx      (sel_idx),
    .sel_ready    (sel_ready),
    .sel_deny     (sel_deny),
`ifdef COIN_RETURN_EN
    .cancel       (cancel),
`endif
    .motor_req    (motor_req),
    .motor_idx    (motor_idx),
    .motor_ack    (motor_ack),
    .change_valid (change_valid),
    .change       (change),
    .change_ack   (change_ack),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_price    (cfg_price),
    .cfg_stock    (cfg_stock),
    .credit       (credit),
    .sold_out     (sold_out),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [4:0] pr, input logic [3:0] st);
    cfg_we = 1'b1; cfg_idx = idx; cfg_price = pr; cfg_stock = st;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic put(input logic [1:0] c);
    coin = c;
    step();
    coin = 2'b00;
  endtask

  task automatic sel(input logic [1:0] idx);
    sel_valid = 1'b1; sel_idx = idx;
    step();
    sel_valid = 1'b0;
  endtask

  task automatic mack();
    motor_ack = 1'b1;
    step();
    motor_ack = 1'b0;
  endtask

  task automatic cack();
    change_ack = 1'b1;
    step();
    change_ack = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; coin = 2'b00; sel_valid = 1'b0; sel_idx = 2'd0; cancel = 1'b0;
    motor_ack = 1'b0; change_ack = 1'b0; cfg_we = 1'b0; cfg_idx = 2'd0;
    cfg_price = 5'd0; cfg_stock = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sold_out", sold_out, 4'hF);
    chk("rst_sel_ready", sel_ready, 1'b1);
    chk("rst_credit", credit, 5'd0);
    chk("rst_motor_req", motor_req, 1'b0);
    chk("rst_change_valid", change_valid, 1'b0);
    chk("rst_change", change, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rejects", {coin_reject, sel_deny}, 2'b00);
    reset_n = 1'b1;
    step();

    // 1: exact-credit vend
    cfg(2'd0, 5'd3, 4'd2);
    put(2'b01);
    put(2'b10);
    chk("t1_credit", credit, 5'd3);
    sel(2'd0);
    chk("t1_motor_req", motor_req, 1'b1);
    chk("t1_motor_idx", motor_idx, 2'd0);
    chk("t1_credit_after", credit, 5'd0);
    chk("t1_sel_ready", sel_ready, 1'b0);
    step();
    chk("t1_motor_hold", motor_req, 1'b1);
    mack();
    chk("t1_motor_drop", motor_req, 1'b0);
    chk("t1_idle", busy, 1'b0);
    chk("t1_no_change", change_valid, 1'b0);

    // 2: vend with one Rs5 change
    cfg(2'd1, 5'd3, 4'd5);
    put(2'b10);
    put(2'b10);
    sel(2'd1);
    chk("t2_motor_idx", motor_idx, 2'd1);
    chk("t2_credit", credit, 5'd1);
    mack();
    chk("t2_change_valid", change_valid, 1'b1);
    chk("t2_change", change, 2'b01);
    chk("t2_busy", busy, 1'b1);
    step();
    chk("t2_change_hold", {change_valid, change}, 3'b101);
    cack();
    chk("t2_credit_end", credit, 5'd0);
    chk("t2_change_done", {change_valid, change}, 3'b000);
    chk("t2_idle", busy, 1'b0);

    // 3: sold-out slot denies
    cfg(2'd2, 5'd1, 4'd0);
    put(2'b10);
    put(2'b10);
    chk("t3_sold_out", sold_out, 4'b1100);
    sel(2'd2);
    chk("t3_deny", sel_deny, 1'b1);
    chk("t3_credit", credit, 5'd4);
    chk("t3_busy", busy, 1'b0);
    step();
    chk("t3_deny_pulse", sel_deny, 1'b0);

    // 4: credit ceiling, bad code, coin during VEND, multi-coin change
    put(2'b10);
    put(2'b10);
    put(2'b01);
    chk("t4_credit9", credit, 5'd9);
    put(2'b10);
    chk("t4_over_reject", coin_reject, 1'b1);
    chk("t4_credit_hold", credit, 5'd9);
    put(2'b11);
    chk("t4_bad_reject", coin_reject, 1'b1);
    put(2'b01);
    chk("t4_credit10", credit, 5'd10);
    chk("t4_accept", coin_reject, 1'b0);
    sel(2'd1);
    chk("t4_credit7", credit, 5'd7);
    put(2'b01);
    chk("t4_vend_reject", coin_reject, 1'b1);
    chk("t4_vend_credit", credit, 5'd7);
    mack();
    chk("t4_chg1", {change_valid, change}, 3'b110);
    cack();
    chk("t4_credit5", credit, 5'd5);
    chk("t4_chg2", {change_valid, change}, 3'b110);
    cack();
    chk("t4_chg3", {change_valid, change}, 3'b110);
    cack();
    chk("t4_credit1", credit, 5'd1);
    chk("t4_chg4", {change_valid, change}, 3'b101);
    cack();
    chk("t4_end", {busy, credit}, 6'd0);

    // 5: same-cycle coin and accepted selection
    put(2'b10);
    put(2'b10);
    coin = 2'b01; sel_valid = 1'b1; sel_idx = 2'd1;
    step();
    coin = 2'b00; sel_valid = 1'b0;
    chk("t5_motor_req", motor_req, 1'b1);
    chk("t5_coin_reject", coin_reject, 1'b1);
    chk("t5_credit", credit, 5'd1);
    chk("t5_sold_out", sold_out, 4'b1100);
    mack();
    cack();
    chk("t5_end", {busy, credit}, 6'd0);

    // cfg write to the selected slot wins over the selection
    put(2'b10);
    put(2'b10);
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_price = 5'd2; cfg_stock = 4'd7;
    sel_valid = 1'b1; sel_idx = 2'd0;
    step();
    cfg_we = 1'b0; sel_valid = 1'b0;
    chk("cfgwin_deny", sel_deny, 1'b1);
    chk("cfgwin_credit", credit, 5'd4);
    chk("cfgwin_busy", busy, 1'b0);

`ifdef COIN_RETURN_EN
    // 6: refund of full credit
    put(2'b01);
    chk("t6_credit5", credit, 5'd5);
    cancel = 1'b1; coin = 2'b01;
    step();
    cancel = 1'b0; coin = 2'b00;
    chk("t6_cancel_reject", coin_reject, 1'b1);
    chk("t6_chg1", {busy, change_valid, change}, 4'b1110);
    cack();
    chk("t6_chg2", {change_valid, change}, 3'b110);
    cack();
    chk("t6_chg3", {change_valid, change}, 3'b101);
    cack();
    chk("t6_end", {busy, credit}, 6'd0);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("t6_cancel_zero", busy, 1'b0);
    put(2'b10);
    put(2'b10);
`endif

    // asynchronous reset during PAYOUT
    sel(2'd0);
    chk("rstmid_credit", credit, 5'd2);
    mack();
    chk("rstmid_payout", {change_valid, change}, 3'b110);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstmid_change", {change_valid, change}, 3'b000);
    chk("rstmid_credit0", credit, 5'd0);
    chk("rstmid_busy", {busy, motor_req}, 2'b00);
    chk("rstmid_sold_out", sold_out, 4'hF);
    step();
    reset_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
